// File: rtl/mem_1r1w_masked_rmw_32x64.sv
// Byte-masked write front end for an unmasked 32x64 single-read/single-write macro.
// Partial writes are emulated by read-modify-write; user reads share the macro read port and win it.
module mem_1r1w_masked_rmw_32x64 (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  R0_addr,
   input  logic        R0_en,
   output logic [63:0] R0_data,
   input  logic [4:0]  W0_addr,
   input  logic        W0_en,
   input  logic [63:0] W0_data,
   input  logic [7:0]  W0_mask,
   output logic        W0_ready,
   output logic [4:0]  MR_addr,
   output logic        MR_en,
   input  logic [63:0] MR_data,
   output logic [4:0]  MW_addr,
   output logic        MW_en,
   output logic [63:0] MW_data
);

   typedef enum logic [1:0] {IDLE, READ, MERGE} state_t;

   state_t      state;
   logic [4:0]  cap_addr;
   logic [63:0] cap_data;
   logic [7:0]  cap_mask;
   logic        fwd_hit;
   logic [63:0] fwd_data;
   logic [7:0]  fwd_mask;
   logic        accept;

   function automatic logic [63:0] merge_bytes(input logic [63:0] new_d,
                                               input logic [63:0] old_d,
                                               input logic [7:0]  m);
      logic [63:0] r;
      for (int i = 0; i < 8; i++)
         r[8*i +: 8] = m[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
      return r;
   endfunction

   assign W0_ready = (state == IDLE) && !reset;
   assign accept   = W0_en && W0_ready;

   // A user read always owns the macro read port; the RMW read only goes out when it is free.
   always_comb begin
      MR_en   = 1'b0;
      MR_addr = cap_addr;
      if (!reset) begin
         if (R0_en) begin
            MR_en   = 1'b1;
            MR_addr = R0_addr;
         end else if (state == READ) begin
            MR_en = 1'b1;
         end
      end
   end

   // A full mask selects every captured byte, so one merge serves both write flavours.
   assign MW_en   = (state == MERGE) && !reset;
   assign MW_addr = cap_addr;
   assign MW_data = merge_bytes(cap_data, MR_data, cap_mask);

   assign R0_data = fwd_hit ? merge_bytes(fwd_data, MR_data, fwd_mask) : MR_data;

   // The macro still holds stale bytes while a write is pending, so reads that hit it patch them next cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         fwd_hit <= 1'b0;
      end else begin
         fwd_hit  <= R0_en && (state != IDLE) && (R0_addr == cap_addr);
         fwd_data <= cap_data;
         fwd_mask <= cap_mask;
         case (state)
            IDLE: begin
               if (accept && (W0_mask != 8'h00)) begin
                  cap_addr <= W0_addr;
                  cap_data <= W0_data;
                  cap_mask <= W0_mask;
                  state    <= (W0_mask == 8'hFF) ? MERGE : READ;
               end
            end
            READ: begin
               if (!R0_en)
                  state <= MERGE;
            end
            MERGE:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_1r1w_masked_rmw_32x64.sv
// Directed, table-driven bench for the masked RMW front end with a behavioural macro model.
module tb_mem_1r1w_masked_rmw_32x64;

   logic        clock;
   logic        reset;
   logic [4:0]  R0_addr;
   logic        R0_en;
   logic [63:0] R0_data;
   logic [4:0]  W0_addr;
   logic        W0_en;
   logic [63:0] W0_data;
   logic [7:0]  W0_mask;
   logic        W0_ready;
   logic [4:0]  MR_addr;
   logic        MR_en;
   logic [63:0] MR_data;
   logic [4:0]  MW_addr;
   logic        MW_en;
   logic [63:0] MW_data;

   logic        preload;
   logic [63:0] macro_mem [32];
   int          total;
   int          passed;

   typedef struct packed {
      logic        rst;
      logic        w_en;
      logic [4:0]  w_addr;
      logic [63:0] w_data;
      logic [7:0]  w_mask;
      logic        r_en;
      logic [4:0]  r_addr;
      logic        exp_ready;
      logic        exp_mr_en;
      logic [4:0]  exp_mr_addr;
      logic        exp_mw_en;
      logic [4:0]  exp_mw_addr;
      logic [63:0] exp_mw_data;
      logic        chk_rdata;
      logic [63:0] exp_rdata;
   } vec_t;

   vec_t tbl [27];

   mem_1r1w_masked_rmw_32x64 dut (
      .clock    (clock),
      .reset    (reset),
      .R0_addr  (R0_addr),
      .R0_en    (R0_en),
      .R0_data  (R0_data),
      .W0_addr  (W0_addr),
      .W0_en    (W0_en),
      .W0_data  (W0_data),
      .W0_mask  (W0_mask),
      .W0_ready (W0_ready),
      .MR_addr  (MR_addr),
      .MR_en    (MR_en),
      .MR_data  (MR_data),
      .MW_addr  (MW_addr),
      .MW_en    (MW_en),
      .MW_data  (MW_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Macro model: registered read returning the old word on a same-edge write.
   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) macro_mem[i] <= 64'h0;
         macro_mem[3] <= 64'h1111_2222_3333_4444;
         macro_mem[9] <= 64'h0123_4567_89AB_CDEF;
         MR_data      <= 64'h0;
      end else begin
         if (MR_en) MR_data <= macro_mem[MR_addr];
         if (MW_en) macro_mem[MW_addr] <= MW_data;
      end
   end

   function automatic vec_t v(input logic rst, input logic we, input logic [4:0] wa,
                              input logic [63:0] wd, input logic [7:0] wm,
                              input logic re, input logic [4:0] ra,
                              input logic rdy, input logic mre, input logic [4:0] mra,
                              input logic mwe, input logic [4:0] mwa, input logic [63:0] mwd,
                              input logic chk, input logic [63:0] er);
      vec_t t;
      t.rst = rst; t.w_en = we; t.w_addr = wa; t.w_data = wd; t.w_mask = wm;
      t.r_en = re; t.r_addr = ra; t.exp_ready = rdy; t.exp_mr_en = mre;
      t.exp_mr_addr = mra; t.exp_mw_en = mwe; t.exp_mw_addr = mwa;
      t.exp_mw_data = mwd; t.chk_rdata = chk; t.exp_rdata = er;
      return t;
   endfunction

   task automatic compareValue(input string name, input int idx,
                               input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp)
         $display("[TB] FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      else
         passed++;
   endtask

   task automatic checkOutput(input vec_t t, input int idx);
      compareValue("W0_ready", idx, {63'h0, W0_ready}, {63'h0, t.exp_ready});
      compareValue("MR_en",    idx, {63'h0, MR_en},    {63'h0, t.exp_mr_en});
      compareValue("MW_en",    idx, {63'h0, MW_en},    {63'h0, t.exp_mw_en});
      if (t.exp_mr_en)
         compareValue("MR_addr", idx, {59'h0, MR_addr}, {59'h0, t.exp_mr_addr});
      if (t.exp_mw_en) begin
         compareValue("MW_addr", idx, {59'h0, MW_addr}, {59'h0, t.exp_mw_addr});
         compareValue("MW_data", idx, MW_data, t.exp_mw_data);
      end
      if (t.chk_rdata)
         compareValue("R0_data", idx, R0_data, t.exp_rdata);
   endtask

   task automatic applyStimulus(input vec_t t, input int idx);
      @(negedge clock);
      reset   = t.rst;
      W0_en   = t.w_en;
      W0_addr = t.w_addr;
      W0_data = t.w_data;
      W0_mask = t.w_mask;
      R0_en   = t.r_en;
      R0_addr = t.r_addr;
      #1;
      checkOutput(t, idx);
   endtask

   initial begin
      logic [63:0] a5;
      logic [63:0] aa;
      total   = 0;
      passed  = 0;
      aa      = 64'hAAAA_AAAA_AAAA_AAAA;
      a5      = 64'hA5A5_A5A5_A5A5_A5A5;
      //           rst we wa  wdata                   wmask  re ra   rdy mre mra mwe mwa mwdata                   chk rdata
      tbl[0]  = v(0, 1, 3, aa,                      8'h0F, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   0, 64'h0);
      tbl[1]  = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   0, 1, 3, 0, 0, 64'h0,                   0, 64'h0);
      tbl[2]  = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   0, 0, 0, 1, 3, 64'h1111_2222_AAAA_AAAA, 0, 64'h0);
      tbl[3]  = v(0, 0, 0, 64'h0,                   8'h00, 1, 3,   1, 1, 3, 0, 0, 64'h0,                   0, 64'h0);
      tbl[4]  = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   1, 64'h1111_2222_AAAA_AAAA);
      tbl[5]  = v(0, 1, 5, 64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   0, 64'h0);
      tbl[6]  = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   0, 0, 0, 1, 5, 64'hDEAD_BEEF_0000_0001, 0, 64'h0);
      tbl[7]  = v(0, 0, 0, 64'h0,                   8'h00, 1, 5,   1, 1, 5, 0, 0, 64'h0,                   0, 64'h0);
      tbl[8]  = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   1, 64'hDEAD_BEEF_0000_0001);
      tbl[9]  = v(0, 1, 6, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   0, 64'h0);
      tbl[10] = v(0, 0, 0, 64'h0,                   8'h00, 1, 6,   1, 1, 6, 0, 0, 64'h0,                   0, 64'h0);
      tbl[11] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   1, 64'h0);
      tbl[12] = v(0, 1, 9, a5,                      8'hF0, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   0, 64'h0);
      tbl[13] = v(0, 0, 0, 64'h0,                   8'h00, 1, 3,   0, 1, 3, 0, 0, 64'h0,                   0, 64'h0);
      tbl[14] = v(0, 0, 0, 64'h0,                   8'h00, 1, 9,   0, 1, 9, 0, 0, 64'h0,                   1, 64'h1111_2222_AAAA_AAAA);
      tbl[15] = v(0, 0, 0, 64'h0,                   8'h00, 1, 5,   0, 1, 5, 0, 0, 64'h0,                   1, 64'hA5A5_A5A5_89AB_CDEF);
      tbl[16] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   0, 1, 9, 0, 0, 64'h0,                   1, 64'hDEAD_BEEF_0000_0001);
      tbl[17] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   0, 0, 0, 1, 9, 64'hA5A5_A5A5_89AB_CDEF, 0, 64'h0);
      tbl[18] = v(0, 0, 0, 64'h0,                   8'h00, 1, 9,   1, 1, 9, 0, 0, 64'h0,                   0, 64'h0);
      tbl[19] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   1, 64'hA5A5_A5A5_89AB_CDEF);
      tbl[20] = v(0, 1, 7, 64'hFF00_0000_0000_0000, 8'h80, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   0, 64'h0);
      tbl[21] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   0, 1, 7, 0, 0, 64'h0,                   0, 64'h0);
      tbl[22] = v(0, 0, 0, 64'h0,                   8'h00, 1, 7,   0, 1, 7, 1, 7, 64'hFF00_0000_0000_0000, 0, 64'h0);
      tbl[23] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   1, 64'hFF00_0000_0000_0000);
      tbl[24] = v(0, 1, 3, 64'h0,                   8'hFF, 1, 3,   1, 1, 3, 0, 0, 64'h0,                   0, 64'h0);
      tbl[25] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   0, 0, 0, 1, 3, 64'h0,                   1, 64'h1111_2222_AAAA_AAAA);
      tbl[26] = v(0, 0, 0, 64'h0,                   8'h00, 0, 0,   1, 0, 0, 0, 0, 64'h0,                   0, 64'h0);

      preload = 1'b1;
      reset   = 1'b1;
      W0_en   = 1'b0;
      W0_addr = 5'd0;
      W0_data = 64'h0;
      W0_mask = 8'h00;
      R0_en   = 1'b0;
      R0_addr = 5'd0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      preload = 1'b0;

      // Held in reset with live requests: nothing may reach the macro.
      applyStimulus(v(1, 1, 3, aa, 8'h0F, 1, 3, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0), 100);

      for (int i = 0; i < 27; i++)
         applyStimulus(tbl[i], i);

      // Reset landing in MERGE drops the pending write; mem[5] must keep its old word.
      applyStimulus(v(0, 1, 5, 64'h0, 8'h0F, 0, 0, 1, 0, 0, 0, 0, 64'h0, 0, 64'h0), 200);
      applyStimulus(v(0, 0, 0, 64'h0, 8'h00, 0, 0, 0, 1, 5, 0, 0, 64'h0, 0, 64'h0), 201);
      applyStimulus(v(1, 0, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0), 202);
      applyStimulus(v(0, 0, 0, 64'h0, 8'h00, 1, 5, 1, 1, 5, 0, 0, 64'h0, 0, 64'h0), 203);
      applyStimulus(v(0, 0, 0, 64'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 64'h0, 1, 64'hDEAD_BEEF_0000_0001), 204);

      // Reset landing in READ likewise abandons the write.
      applyStimulus(v(0, 1, 5, 64'h0, 8'h01, 0, 0, 1, 0, 0, 0, 0, 64'h0, 0, 64'h0), 300);
      applyStimulus(v(1, 0, 0, 64'h0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 64'h0, 0, 64'h0), 301);
      applyStimulus(v(0, 0, 0, 64'h0, 8'h00, 1, 5, 1, 1, 5, 0, 0, 64'h0, 0, 64'h0), 302);
      applyStimulus(v(0, 0, 0, 64'h0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 64'h0, 1, 64'hDEAD_BEEF_0000_0001), 303);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mem_1r1w_masked_rmw_32x64.md
MEM_1R1W_MASKED_RMW_32X64 -- requirements
Module: mem_1r1w_masked_rmw_32x64

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all state changes on rising edge of clock.
REQ-002 SHALL have parameters: none; fixed depth 32, width 64, mask granularity 8 bits (8 mask bits).
REQ-003 clock  input  1  sole clock; memory-side ports are synchronous to it.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 R0_addr  input  5  user read address.
REQ-006 R0_en  input  1  user read request; always accepted.
REQ-007 R0_data  output  64  user read data, valid the cycle after R0_en.
REQ-008 W0_addr  input  5  user write address.
REQ-009 W0_en  input  1  user write request.
REQ-010 W0_data  input  64  user write data.
REQ-011 W0_mask  input  8  byte enables; bit i covers W0_data[8i+7:8i].
REQ-012 W0_ready  output  1  write accepted when W0_en && W0_ready.
REQ-013 MR_addr  output  5  macro read address.
REQ-014 MR_en  output  1  macro read enable, active-high.
REQ-015 MR_data  input  64  macro read data, valid the cycle after MR_en.
REQ-016 MW_addr  output  5  macro write address.
REQ-017 MW_en  output  1  macro write enable, active-high, unmasked full-word write.
REQ-018 MW_data  output  64  macro write data.

Function
REQ-019 SHALL emulate byte-masked writes on the unmasked macro by read-modify-write (RMW).
REQ-020 SHALL implement FSM states IDLE, READ, MERGE; W0_ready = (state==IDLE) && !reset.
REQ-021 IDLE, accept with W0_mask==8'hFF: capture addr/data/mask, go MERGE (no macro read).
REQ-022 IDLE, accept with W0_mask==8'h00: no macro access, remain IDLE.
REQ-023 IDLE, accept with any other mask: capture addr/data/mask, go READ.
REQ-024 READ: if R0_en==0, drive MR_en=1, MR_addr=captured addr, go MERGE; if R0_en==1, user read wins the macro read port, stay READ.
REQ-025 MERGE: drive MW_en=1, MW_addr=captured addr; for partial writes MW_data byte i = mask[i] ? captured data byte i : MR_data byte i; for full mask MW_data = captured data; go IDLE.
REQ-026 Occupancy: full-mask write 2 cycles, partial write 3 cycles plus one per READ-state stall.
REQ-027 User read: when R0_en==1, MR_en=1 and MR_addr=R0_addr combinationally, in every state.
REQ-028 R0_data = MR_data in the cycle after a user read, subject to REQ-029.
REQ-029 Forwarding: if R0_en in a cycle where state is READ or MERGE and R0_addr==captured addr, R0_data byte i = captured data byte i for each mask[i]==1, MR_data byte i otherwise.
REQ-030 A read SHALL observe only writes accepted in earlier cycles; a write accepted in the same cycle is not visible.
REQ-031 MW_en and the RMW MR_en SHALL never assert in the same cycle for the same operation; MR_en and MW_en to the same address in MERGE SHALL rely on REQ-029, not macro read-during-write behaviour.
REQ-032 In cycles with no user read, R0_data is don't-care.

Reset
REQ-033 While reset==1: state->IDLE, W0_ready=0, MR_en=0, MW_en=0, forwarding-hit flag cleared.
REQ-034 Reset during READ or MERGE SHALL abandon the pending write with no MW_en pulse; memory contents untouched by the block.
REQ-035 First cycle after reset deassertion: W0_ready=1.

Verification
REQ-036 Mem[3]=64'h1111_2222_3333_4444; write addr 3, data all 64'hAAAA..., mask 8'h0F -> MR_en at READ, MW_data=64'h1111_2222_AAAA_AAAA two cycles after accept, W0_ready low for 2 cycles.
REQ-037 Write addr 5, mask 8'hFF, data 64'hDEAD_BEEF_0000_0001 -> no RMW MR_en, MW_en one cycle after accept, W0_ready low 1 cycle.
REQ-038 Write mask 8'h00 -> W0_ready stays 1, no MR_en/MW_en.
REQ-039 Partial write pending in READ with R0_en=1 for 3 cycles -> state held READ 3 cycles, user reads serviced, write completes afterward with correct merge.
REQ-040 Mem[7]=0; write addr 7 mask 8'h80 data 64'hFF00...; read addr 7 during MERGE -> R0_data=64'hFF00_0000_0000_0000.
REQ-041 Reset asserted in MERGE -> MW_en=0 that cycle, W0_ready=1 after release, Mem unchanged.
